// File: rtl/sound_sequencer_if.sv
// CPU staging port and sound-engine register port bundled for sound_sequencer.
// master = CPU/engine side driving inputs, slave = the sequencer.
interface sound_sequencer_if;
  logic [2:0] cpu_addr;
  logic [7:0] cpu_data_in;
  logic       cpu_write;
  logic [7:0] cpu_status;
  logic [3:0] snd_addr;
  logic [7:0] snd_data;
  logic       snd_write;
  logic       snd_busy;

  modport master (
    output cpu_addr, cpu_data_in, cpu_write, snd_busy,
    input  cpu_status, snd_addr, snd_data, snd_write
  );

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_write, snd_busy,
    output cpu_status, snd_addr, snd_data, snd_write
  );
endinterface

// File: rtl/sound_sequencer.sv
// Descriptor FIFO plus replay FSM driving the ADPCM engine register port.
// Optional looping playback is enabled by defining SOUND_SEQ_LOOP_EN.
module sound_sequencer #(
  parameter int ROM_WIDTH   = 16,
  parameter int QUEUE_DEPTH = 4
) (
  input logic              clk,
  input logic              reset_n,
  sound_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
`ifdef SOUND_SEQ_LOOP_EN
  localparam int ENTRY_W = 2 * ROM_WIDTH + 9;
`else
  localparam int ENTRY_W = 2 * ROM_WIDTH + 8;
`endif
  localparam logic [3:0] DEPTH_C = 4'(QUEUE_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_KILL} state_t;

  logic [7:0]           r_start_lo, r_start_hi, r_end_lo, r_end_hi, r_vol;
  logic [ENTRY_W-1:0]   r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr, r_wr_ptr;
  logic [3:0]           r_count;
  logic                 r_overflow;
  state_t               r_state, w_seq_state, w_next_state;
  logic [2:0]           r_idx, w_next_idx;
  logic [ROM_WIDTH-1:0] r_act_start, r_act_end;
  logic [7:0]           r_act_vol;
  logic                 r_snd_write, w_snd_write;
  logic [3:0]           r_snd_addr, w_snd_addr;
  logic [7:0]           r_snd_data, w_snd_data;
  logic                 w_cmd, w_stop, w_prio, w_enq, w_flush;
  logic                 w_push, w_pop, w_empty, w_full;
  logic [15:0]          w_stage_start, w_stage_end, w_act_start16, w_act_end16;
  logic [ENTRY_W-1:0]   w_new_entry, w_head;
  logic [ROM_WIDTH-1:0] w_head_start, w_head_end;
  logic [7:0]           w_head_vol;
  logic                 w_unused;
`ifdef SOUND_SEQ_LOOP_EN
  logic                 r_act_loop, w_head_loop;
`endif

  // Command decode: stop outranks priority, which outranks enqueue.
  assign w_cmd   = bus.cpu_write && (bus.cpu_addr == 3'd5);
  assign w_stop  = w_cmd && bus.cpu_data_in[1];
  assign w_prio  = w_cmd && !bus.cpu_data_in[1] && bus.cpu_data_in[2];
  assign w_enq   = w_cmd && !bus.cpu_data_in[1] && !bus.cpu_data_in[2] && bus.cpu_data_in[0];
  assign w_flush = w_stop || w_prio;

  assign w_empty = (r_count == 4'd0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_push  = w_enq && (!w_full || w_pop);

  assign w_stage_start = {r_start_hi, r_start_lo};
  assign w_stage_end   = {r_end_hi, r_end_lo};
`ifdef SOUND_SEQ_LOOP_EN
  assign w_new_entry = {bus.cpu_data_in[3], w_stage_start[ROM_WIDTH-1:0],
                        w_stage_end[ROM_WIDTH-1:0], r_vol};
  assign w_head_loop = w_head[2*ROM_WIDTH+8];
`else
  assign w_new_entry = {w_stage_start[ROM_WIDTH-1:0], w_stage_end[ROM_WIDTH-1:0], r_vol};
`endif
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_vol   = w_head[7:0];
  assign w_head_end   = w_head[ROM_WIDTH+7:8];
  assign w_head_start = w_head[2*ROM_WIDTH+7:ROM_WIDTH+8];
  assign w_act_start16 = 16'(r_act_start);
  assign w_act_end16   = 16'(r_act_end);
  assign w_unused = ^{bus.cpu_data_in[7:3], w_stage_start, w_stage_end};

  // CPU staging registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_lo <= 8'h00;
      r_start_hi <= 8'h00;
      r_end_lo   <= 8'h00;
      r_end_hi   <= 8'h00;
      r_vol      <= 8'h00;
    end else if (bus.cpu_write) begin
      case (bus.cpu_addr)
        3'd0:    r_start_lo <= bus.cpu_data_in;
        3'd1:    r_start_hi <= bus.cpu_data_in;
        3'd2:    r_end_lo   <= bus.cpu_data_in;
        3'd3:    r_end_hi   <= bus.cpu_data_in;
        3'd4:    r_vol      <= bus.cpu_data_in;
        default: r_vol      <= r_vol;
      endcase
    end
  end

  // FIFO storage; a priority command always lands in slot 0 after the flush.
  always_ff @(posedge clk) begin
    if (w_prio) begin
      r_mem[0] <= w_new_entry;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_new_entry;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= 4'd0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= w_prio ? PTR_W'(1'b1) : '0;
      r_count    <= w_prio ? 4'd1 : 4'd0;
      r_overflow <= w_stop ? 1'b0 : r_overflow;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      if (w_enq && !w_push) r_overflow <= 1'b1;
    end
  end

  // Next-state and burst generation; the write chosen here is registered onto the port.
  always_comb begin
    w_seq_state = r_state;
    w_next_idx  = r_idx;
    w_pop       = 1'b0;
    w_snd_write = 1'b0;
    w_snd_addr  = 4'd0;
    w_snd_data  = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (!w_flush && !w_empty) begin
          w_pop       = 1'b1;
          w_seq_state = S_LOAD;
          w_next_idx  = 3'd0;
        end else begin
          w_seq_state = S_IDLE;
        end
      end
      S_LOAD: begin
        w_snd_write = 1'b1;
        case (r_idx)
          3'd0:    begin w_snd_addr = 4'd12; w_snd_data = r_act_vol;            end
          3'd1:    begin w_snd_addr = 4'd0;  w_snd_data = w_act_start16[7:0];   end
          3'd2:    begin w_snd_addr = 4'd1;  w_snd_data = w_act_start16[15:8];  end
          3'd3:    begin w_snd_addr = 4'd4;  w_snd_data = w_act_end16[7:0];     end
          3'd4:    begin w_snd_addr = 4'd5;  w_snd_data = w_act_end16[15:8];    end
          default: begin w_snd_addr = 4'd8;  w_snd_data = 8'h00;                end
        endcase
        if (r_idx == 3'd5) begin
          w_seq_state = S_SETTLE;
        end else begin
          w_next_idx = r_idx + 3'd1;
        end
      end
      S_SETTLE: w_seq_state = S_WAIT;
      S_WAIT: begin
        if (!bus.snd_busy) begin
`ifdef SOUND_SEQ_LOOP_EN
          if (r_act_loop && w_empty) begin
            w_seq_state = S_LOAD;
            w_next_idx  = 3'd0;
          end else begin
            w_seq_state = S_IDLE;
          end
`else
          w_seq_state = S_IDLE;
`endif
        end else begin
          w_seq_state = S_WAIT;
        end
      end
      S_KILL: begin
        w_snd_write = 1'b1;
        w_snd_addr  = 4'd12;
        w_snd_data  = r_act_vol;
        w_seq_state = S_IDLE;
      end
      default: w_seq_state = S_IDLE;
    endcase
  end

  assign w_next_state = (w_flush && (r_state != S_IDLE)) ? S_KILL : w_seq_state;

  // State, active descriptor and registered engine-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_act_start <= '0;
      r_act_end   <= '0;
      r_act_vol   <= 8'h00;
      r_snd_write <= 1'b0;
      r_snd_addr  <= 4'd0;
      r_snd_data  <= 8'h00;
`ifdef SOUND_SEQ_LOOP_EN
      r_act_loop  <= 1'b0;
`endif
    end else begin
      r_state     <= w_next_state;
      r_idx       <= w_next_idx;
      r_snd_write <= w_snd_write;
      r_snd_addr  <= w_snd_addr;
      r_snd_data  <= w_snd_data;
      if (w_pop) begin
        r_act_start <= w_head_start;
        r_act_end   <= w_head_end;
        r_act_vol   <= w_head_vol;
`ifdef SOUND_SEQ_LOOP_EN
        r_act_loop  <= w_head_loop;
`endif
      end
    end
  end

  assign bus.cpu_status = {r_overflow, r_count, w_empty, w_full, (r_state != S_IDLE)};
  assign bus.snd_write  = r_snd_write;
  assign bus.snd_addr   = r_snd_addr;
  assign bus.snd_data   = r_snd_data;
endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: expected engine writes are queued as stimulus is
// applied and matched by a negedge monitor; status and timing are checked inline.
module tb_sound_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          play_len = 10;
  int          eng_cnt = 0;
  logic [11:0] exp_q [$];
  logic [11:0] mon_exp;

  sound_sequencer_if bus ();

  sound_sequencer #(.ROM_WIDTH(16), .QUEUE_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Engine model: a trigger write starts play_len busy cycles, any other write halts it.
  always @(negedge clk) begin
    if (!reset_n) eng_cnt = 0;
    else if (bus.snd_write) eng_cnt = (bus.snd_addr == 4'd8) ? play_len : 0;
    else if (eng_cnt > 0) eng_cnt = eng_cnt - 1;
    bus.snd_busy = (eng_cnt != 0);
  end

  // Write monitor against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && bus.snd_write) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: observed %h expected none", {bus.snd_addr, bus.snd_data});
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        vectors++;
        assert ({bus.snd_addr, bus.snd_data} === mon_exp) else begin
          miscompares++;
          $error("FAIL snd_write_data: observed %h expected %h", {bus.snd_addr, bus.snd_data}, mon_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.cpu_addr    = a;
    bus.cpu_data_in = d;
    bus.cpu_write   = 1'b1;
    @(negedge clk);
    bus.cpu_write   = 1'b0;
  endtask

  task automatic stage(input logic [15:0] s, input logic [15:0] e, input logic [7:0] v);
    wr(3'd0, s[7:0]);
    wr(3'd1, s[15:8]);
    wr(3'd2, e[7:0]);
    wr(3'd3, e[15:8]);
    wr(3'd4, v);
  endtask

  task automatic push_burst(input logic [15:0] s, input logic [15:0] e, input logic [7:0] v);
    exp_q.push_back({4'd12, v});
    exp_q.push_back({4'd0, s[7:0]});
    exp_q.push_back({4'd1, s[15:8]});
    exp_q.push_back({4'd4, e[7:0]});
    exp_q.push_back({4'd5, e[15:8]});
    exp_q.push_back({4'd8, 8'h00});
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 16'(exp_q.size()), 16'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.cpu_status[0] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {15'd0, bus.cpu_status[0]}, 16'd0);
  endtask

  initial begin
    logic [15:0] s, e;
    logic [7:0]  v;
    bus.cpu_addr    = 3'd0;
    bus.cpu_data_in = 8'h00;
    bus.cpu_write   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_status", {8'd0, bus.cpu_status}, 16'h0004);
    chk("rst_write", {15'd0, bus.snd_write}, 16'd0);
    chk("rst_addr_data", {4'd0, bus.snd_addr, bus.snd_data}, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single descriptor: latency and burst shape
    play_len = 10;
    stage(16'h0100, 16'h0180, 8'h40);
    push_burst(16'h0100, 16'h0180, 8'h40);
    wr(3'd5, 8'h01);
    chk("lat_status_n", {8'd0, bus.cpu_status}, 16'h0008);
    chk("lat_write_n", {15'd0, bus.snd_write}, 16'd0);
    @(negedge clk);
    chk("lat_write_n1", {15'd0, bus.snd_write}, 16'd0);
    chk("lat_status_n1", {8'd0, bus.cpu_status}, 16'h0005);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("burst_consecutive", {15'd0, bus.snd_write}, 16'd1);
    end
    @(negedge clk);
    chk("burst_end", {15'd0, bus.snd_write}, 16'd0);
    chk("wait_busy", {8'd0, bus.cpu_status}, 16'h0005);
    wait_idle("t1_idle", 100);
    chk("t1_status", {8'd0, bus.cpu_status}, 16'h0004);

    // Overflow: five enqueues while the engine is busy
    play_len = 60;
    stage(16'h0200, 16'h0280, 8'h11);
    push_burst(16'h0200, 16'h0280, 8'h11);
    wr(3'd5, 8'h01);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      s = 16'h1000 + 16'(i) * 16'h0100;
      e = s + 16'h0040;
      v = 8'h50 + 8'(i);
      stage(s, e, v);
      if (i < 4) push_burst(s, e, v);
      wr(3'd5, 8'h01);
    end
    chk("ovf_status", {8'd0, bus.cpu_status}, 16'h00A3);
    play_len = 8;
    drain("ovf_drain", 1000);
    wait_idle("ovf_idle", 100);
    chk("ovf_sticky", {8'd0, bus.cpu_status}, 16'h0084);
    wr(3'd5, 8'h02);
    chk("stop_clears_ovf", {8'd0, bus.cpu_status}, 16'h0004);

    // Stop during WAIT with two queued
    play_len = 100;
    stage(16'h2000, 16'h2100, 8'h33);
    push_burst(16'h2000, 16'h2100, 8'h33);
    wr(3'd5, 8'h01);
    stage(16'h2200, 16'h2300, 8'h34);
    wr(3'd5, 8'h01);
    stage(16'h2400, 16'h2500, 8'h35);
    wr(3'd5, 8'h01);
    chk("stop_pre_status", {8'd0, bus.cpu_status}, 16'h0011);
    exp_q.push_back({4'd12, 8'h33});
    wr(3'd5, 8'h02);
    chk("stop_kill_status", {8'd0, bus.cpu_status}, 16'h0005);
    @(negedge clk);
    chk("stop_kill_write", {15'd0, bus.snd_write}, 16'd1);
    chk("stop_after_status", {8'd0, bus.cpu_status}, 16'h0004);
    repeat (30) @(negedge clk);
    chk("stop_quiet", {8'd0, bus.cpu_status}, 16'h0004);

    // Priority during LOAD, with a push on the same edge as a pop
    play_len = 6;
    stage(16'h3344, 16'h3A00, 8'h21);
    exp_q.push_back({4'd12, 8'h21});
    exp_q.push_back({4'd0, 8'h44});
    exp_q.push_back({4'd1, 8'h33});
    exp_q.push_back({4'd12, 8'h21});
    push_burst(16'h3355, 16'h3A00, 8'h77);
    wr(3'd5, 8'h01);
    wr(3'd5, 8'h01);
    chk("push_pop_count", {8'd0, bus.cpu_status}, 16'h0009);
    wr(3'd4, 8'h77);
    wr(3'd0, 8'h55);
    wr(3'd5, 8'h04);
    chk("prio_status", {8'd0, bus.cpu_status}, 16'h0009);
    drain("prio_drain", 200);
    wait_idle("prio_idle", 100);
    repeat (20) @(negedge clk);
    chk("prio_final", {8'd0, bus.cpu_status}, 16'h0004);

`ifdef SOUND_SEQ_LOOP_EN
    // Loop entry re-bursts until stopped
    play_len = 5;
    stage(16'h4000, 16'h4010, 8'h66);
    for (int r = 0; r < 3; r++) push_burst(16'h4000, 16'h4010, 8'h66);
    wr(3'd5, 8'h09);
    drain("loop_drain", 300);
    exp_q.push_back({4'd12, 8'h66});
    wr(3'd5, 8'h02);
    drain("loop_kill", 20);
    wait_idle("loop_idle", 20);
    repeat (20) @(negedge clk);
    chk("loop_final", {8'd0, bus.cpu_status}, 16'h0004);
`else
    // Loop bit ignored: entry plays once
    play_len = 5;
    stage(16'h4000, 16'h4010, 8'h66);
    push_burst(16'h4000, 16'h4010, 8'h66);
    wr(3'd5, 8'h09);
    drain("noloop_drain", 100);
    wait_idle("noloop_idle", 50);
    repeat (20) @(negedge clk);
    chk("noloop_final", {8'd0, bus.cpu_status}, 16'h0004);
`endif

    // Asynchronous reset mid-LOAD
    play_len = 10;
    stage(16'h5000, 16'h5100, 8'h7A);
    exp_q.push_back({4'd12, 8'h7A});
    exp_q.push_back({4'd0, 8'h00});
    wr(3'd5, 8'h01);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_write", {15'd0, bus.snd_write}, 16'd0);
    chk("arst_status", {8'd0, bus.cpu_status}, 16'h0004);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_quiet", {8'd0, bus.cpu_status}, 16'h0004);
    chk("all_issued", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
